// File: rtl/sr_drv_pkg.sv
// sr_drv_pkg: shared types and helpers for the gated SR-latch driver.
// Holds the phase enum, command encodings and timer sizing helpers.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GUARD
  } state_t;

  localparam logic CMD_SET = 1'b1;
  localparam logic CMD_RST = 1'b0;

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

  // Never narrower than one bit, even when every phase width is zero.
  function automatic int tmr_width(
    input int max_w
  );
    int w;
    w = $clog2(max_w + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// sr_drv_timer: loadable down-counter with zero flag.
// One instance times every phase of the latch driver.
module sr_drv_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Holds at zero rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: handshaked set/reset commands to timed s/r/en waveforms.
// Optional q readback check enabled by defining SR_DRV_READBACK_EN.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int SETUP_W = 1,
  parameter int PULSE_W = 4,
  parameter int HOLD_W  = 1,
  parameter int GUARD_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_set,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic en,
  output logic busy,
  output logic done,
  input  logic q_in,
  output logic err,
  input  logic err_clr
);

  localparam int MAX_W = max2(
    max2(SETUP_W, PULSE_W),
    max2(HOLD_W, GUARD_W)
  );
  localparam int TW = tmr_width(MAX_W);

  state_t          state;
  state_t          nxt;
  logic            cmd;
  logic            cmd_nxt;
  logic            load;
  logic [TW-1:0]   load_val;
  logic            tmr_zero;
  logic            drv_nxt;

  // Next phase with a non-zero width; PULSE is never skipped.
  function automatic state_t after(
    input state_t st
  );
    state_t n;
    n = IDLE;
    case (st)
      IDLE:    n = (SETUP_W > 0) ? SETUP : PULSE;
      SETUP:   n = PULSE;
      PULSE:   n = (HOLD_W > 0)  ? HOLD  :
                   (GUARD_W > 0) ? GUARD : IDLE;
      HOLD:    n = (GUARD_W > 0) ? GUARD : IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  function automatic int width_of(
    input state_t st
  );
    int w;
    w = 0;
    case (st)
      SETUP:   w = SETUP_W;
      PULSE:   w = PULSE_W;
      HOLD:    w = HOLD_W;
      GUARD:   w = GUARD_W;
      default: w = 0;
    endcase
    return w;
  endfunction

  always_comb begin
    nxt     = state;
    load    = 1'b0;
    cmd_nxt = cmd;
    if (state == IDLE) begin
      if (req_valid && req_ready) begin
        nxt     = after(IDLE);
        load    = 1'b1;
        cmd_nxt = req_set;
      end
    end else if (tmr_zero) begin
      nxt  = after(state);
      load = 1'b1;
    end
  end

  assign load_val = (nxt == IDLE) ? '0 :
                    TW'(width_of(nxt) - 1);

  assign drv_nxt = (nxt == SETUP) ||
                   (nxt == PULSE) ||
                   (nxt == HOLD);

  sr_drv_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (tmr_zero)
  );

  // Outputs decode the next state so every pin comes straight off a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= CMD_RST;
      s         <= 1'b0;
      r         <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= nxt;
      cmd       <= cmd_nxt;
      s         <= drv_nxt & cmd_nxt;
      r         <= drv_nxt & ~cmd_nxt;
      en        <= (nxt == PULSE);
      busy      <= (nxt != IDLE);
      done      <= (nxt == IDLE) && (state != IDLE);
      req_ready <= (nxt == IDLE);
    end
  end

`ifdef SR_DRV_READBACK_EN
  logic [1:0] q_sync;
  logic [1:0] chk_pipe;
  logic [1:0] cmd_pipe;
  logic       chk_now;
  logic       mismatch;

  // Check point is the last cycle s/r are driven; pipe aligns it with q_sync.
  assign chk_now = tmr_zero &&
                   ((state == HOLD) ||
                    ((state == PULSE) && (HOLD_W == 0)));

  assign mismatch = chk_pipe[1] &&
                    (q_sync[1] != cmd_pipe[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sync   <= '0;
      chk_pipe <= '0;
      cmd_pipe <= '0;
      err      <= 1'b0;
    end else begin
      q_sync   <= {q_sync[0], q_in};
      chk_pipe <= {chk_pipe[0], chk_now};
      cmd_pipe <= {cmd_pipe[0], cmd};
      err      <= (err & ~err_clr) | mismatch;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = q_in ^ err_clr;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed table, corner sequences and random traffic
// against an offset-arithmetic model of the s/r/en waveform.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic v, st, rdy, s, r, en, busy, done, q_in, err, err_clr;
  logic v0, st0, rdy0, s0, r0, en0, busy0, done0, q0, err0;
  logic err_clr0 = 1'b0;

  logic lq = 1'b0;
  logic lq0 = 1'b0;
  logic force0 = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

`ifdef SR_DRV_READBACK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural gated latches seen by each driver.
  always @(negedge clk) begin
    if (en && s) lq = 1'b1;
    else if (en && r) lq = 1'b0;
    if (en0 && s0) lq0 = 1'b1;
    else if (en0 && r0) lq0 = 1'b0;
  end
  assign q_in = force0 ? 1'b0 : lq;
  assign q0   = lq0;

  sr_latch_driver dut (
    .clk(clk), .rst(rst),
    .req_valid(v), .req_set(st), .req_ready(rdy),
    .s(s), .r(r), .en(en), .busy(busy), .done(done),
    .q_in(q_in), .err(err), .err_clr(err_clr)
  );

  sr_latch_driver #(
    .SETUP_W(0), .PULSE_W(1), .HOLD_W(0), .GUARD_W(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_set(st0), .req_ready(rdy0),
    .s(s0), .r(r0), .en(en0), .busy(busy0), .done(done0),
    .q_in(q0), .err(err0), .err_clr(err_clr0)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Expected {s,r,en,busy,done,ready}, k cycles after the accepting cycle.
  function automatic logic [5:0] model(input int k, input bit has,
                                       input bit cmd, input int sw,
                                       input int pw, input int hw,
                                       input int gw);
    int  l;
    bit  drv, pen, bsy, dn;
    if (!has) return 6'b000001;
    l   = sw + pw + hw + gw + 1;
    drv = (k >= 1) && (k <= sw + pw + hw);
    pen = (k > sw) && (k <= sw + pw);
    bsy = (k >= 1) && (k < l);
    dn  = (k == l);
    return {drv & cmd, drv & ~cmd, pen, bsy, dn, ~bsy};
  endfunction

  // s&r never; s/r frozen while en stays high.
  logic sp = 0, rp = 0, enp = 0, sp0 = 0, rp0 = 0, enp0 = 0;
  always @(negedge clk) begin
    if (!rst) begin
      check("sr_safe", 32'((s & r) |
            (en & enp & ((s ^ sp) | (r ^ rp)))), 32'd0);
      check("sr_safe0", 32'((s0 & r0) |
            (en0 & enp0 & ((s0 ^ sp0) | (r0 ^ rp0)))), 32'd0);
    end
    sp = s; rp = r; enp = en;
    sp0 = s0; rp0 = r0; enp0 = en0;
  end

  typedef struct packed {
    logic       v;
    logic       st;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [11];

  int        n, a, a0;
  bit        dn, has, has0, cmd, cmd0, pv, ps, pv0, ps0;
  logic [5:0] e, e0;

  initial begin
    v = 0; st = 0; v0 = 0; st0 = 0; err_clr = 0;

    tbl[0]  = '{1'b1, 1'b1, 6'b000001};
    tbl[1]  = '{1'b0, 1'b0, 6'b100100};
    tbl[2]  = '{1'b0, 1'b0, 6'b101100};
    tbl[3]  = '{1'b0, 1'b0, 6'b101100};
    tbl[4]  = '{1'b0, 1'b0, 6'b101100};
    tbl[5]  = '{1'b0, 1'b0, 6'b101100};
    tbl[6]  = '{1'b0, 1'b0, 6'b100100};
    tbl[7]  = '{1'b0, 1'b0, 6'b000100};
    tbl[8]  = '{1'b0, 1'b0, 6'b000100};
    tbl[9]  = '{1'b0, 1'b0, 6'b000011};
    tbl[10] = '{1'b0, 1'b0, 6'b000001};

    repeat (2) @(negedge clk);
    check("reset_state",
          32'({s, r, en, busy, done, rdy, err}), 32'd0);
    rst = 0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("tbl%0d", i),
            32'({s, r, en, busy, done, rdy}), 32'(tbl[i].exp));
      v  = tbl[i].v;
      st = tbl[i].st;
    end

    // Async reset in the middle of the enable pulse.
    @(negedge clk); v = 1; st = 1;
    @(negedge clk); v = 0;
    n = 0;
    while (!en && n < 10) begin @(negedge clk); n++; end
    check("rst_en_reached", 32'(en), 32'd1);
    #2 rst = 1;
    #1 check("rst_async",
             32'({s, r, en, busy, done, rdy, err}), 32'd0);
    @(negedge clk); rst = 0;
    dn = 0;
    repeat (12) begin @(negedge clk); dn |= done; end
    check("rst_no_done", 32'(dn), 32'd0);

    // Reset then set, held valid; second taken in the done cycle.
    @(negedge clk);
    check("b2b_ready", 32'(rdy), 32'd1);
    v = 1; st = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) st = 1;
      if (k == 3)
        check("busy_hold", 32'({r, en, rdy}), 32'b110);
      if (k == 9)
        check("b2b_done", 32'({done, rdy}), 32'b11);
      if (k == 10) begin
        check("b2b_second", 32'({s, r}), 32'b10);
        v = 0;
      end
    end
    repeat (12) @(negedge clk);

    // Zero-width phases: single en cycle, done two cycles after accept.
    @(negedge clk);
    check("zw_ready", 32'(rdy0), 32'd1);
    v0 = 1; st0 = 1;
    @(negedge clk); v0 = 0;
    check("zw_pulse", 32'({s0, r0, en0, done0}), 32'b1010);
    @(negedge clk);
    check("zw_done", 32'({s0, r0, en0, done0}), 32'b0001);
    @(negedge clk);
    check("zw_idle", 32'({en0, done0, rdy0}), 32'b001);

    // Readback: latch stuck at 0 on a set command.
    force0 = 1;
    @(negedge clk); v = 1; st = 1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) v = 0;
      if (k == 10) check("rb_err_set", 32'(err), 32'(EXP_ERR));
      if (k == 12) begin
        check("rb_err_sticky", 32'(err), 32'(EXP_ERR));
        err_clr = 1;
      end
      if (k == 13) begin
        err_clr = 0;
        check("rb_err_clr", 32'(err), 32'd0);
      end
    end
    force0 = 0;
    repeat (3) @(negedge clk);

    // Random traffic on both instances.
    has = 0; has0 = 0; pv = 0; pv0 = 0;
    a = 0; a0 = 0; cmd = 0; cmd0 = 0; ps = 0; ps0 = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      e  = model(cyc - a, has, cmd, 1, 4, 1, 2);
      e0 = model(cyc - a0, has0, cmd0, 0, 1, 0, 0);
      check("rand",
            32'({s, r, en, busy, done, rdy, err}), 32'({e, 1'b0}));
      check("rand0",
            32'({s0, r0, en0, busy0, done0, rdy0, err0}),
            32'({e0, 1'b0}));
      if (!pv) begin
        pv = ($urandom_range(2) == 0);
        ps = 1'($urandom_range(1));
      end
      v = pv; st = ps;
      if (pv && e[0]) begin
        a = cyc; has = 1; cmd = ps; pv = 0;
      end
      if (!pv0) begin
        pv0 = ($urandom_range(2) == 0);
        ps0 = 1'($urandom_range(1));
      end
      v0 = pv0; st0 = ps0;
      if (pv0 && e0[0]) begin
        a0 = cyc; has0 = 1; cmd0 = ps0; pv0 = 0;
      end
    end
    v = 0; v0 = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
